// File: rtl/crypto_round_engine.sv
// crypto_round_engine
//   Iterative rotate/XOR block cipher. One DATA_W word is processed per
//   transaction, one round per clock, NUM_ROUNDS rounds in total.
//   sel_i = 0 encrypts and sel_i = 1 decrypts. The two modes are exact inverses.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   source presents data_in_i / key_i / sel_i
//   in_ready_o   engine can accept a transaction (IDLE only)
//   sel_i        0 = encrypt, 1 = decrypt
//   data_in_i    plaintext (encrypt) or ciphertext (decrypt)
//   key_i        cipher key
//   out_valid_o  result_o is valid (DONE)
//   out_ready_i  sink accepts result
//   result_o     processed word, holds its last value after hand-off
//   busy_o       high in RUN or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid_i; in_ready_o high
// RUN   | one round applied per edge; round counter steps toward last
// DONE  | out_valid_o high, result_o held until out_ready_i
module crypto_round_engine #(
  parameter int DATA_W     = 32,
  parameter int NUM_ROUNDS = 4,
  parameter int ROT        = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              sel_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic [DATA_W-1:0] key_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              busy_o
);

  localparam int CW = $clog2(NUM_ROUNDS);
  localparam logic [CW-1:0] LAST = CW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] key_q;
  logic              sel_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] result_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [DATA_W-1:0] round_key;
  logic [DATA_W-1:0] data_d;
  logic              last_round;

  // Rotate via a doubled word so a zero amount needs no special case.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int n);
    logic [2*DATA_W-1:0] t;
    t = {x, x} << (n % DATA_W);
    return t[2*DATA_W-1 -: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return rotl(x, (DATA_W - (n % DATA_W)) % DATA_W);
  endfunction

  always_comb begin
    round_key  = rotl(key_q, 32'(cnt_q));
    data_d     = sel_q ? (rotr(data_q, ROT) ^ round_key)
                       : rotl(data_q ^ round_key, ROT);
    // Decrypt walks the rounds backwards, so its last round is index 0.
    last_round = sel_q ? (cnt_q == '0) : (cnt_q == LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      key_q       <= '0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            data_q     <= data_in_i;
            key_q      <= key_i;
            sel_q      <= sel_i;
            cnt_q      <= sel_i ? LAST : '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          data_q <= data_d;
          if (last_round) begin
            // Counter is left at its final index so it never leaves range.
            state_q     <= S_DONE;
            result_q    <= data_d;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= sel_q ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign busy_o      = busy_q;

endmodule
